// File: rtl/rvx_core_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rvx_core_redirect_ctrl
// Purpose  : Sequences control-flow redirects from the branch comparator and
//            the trap logic. It captures a taken branch/jump or trap target,
//            holds a redirect request until fetch accepts it, flushes stage 0
//            and stalls stage 1 while the redirect is outstanding, and then
//            discards DRAIN_CYCLES in-flight fetch responses.
// Revision : 1.0 - initial release
//
// Ports
//   clock             in   1   core clock, rising edge
//   reset_n           in   1   synchronous active-low reset
//   valid_s1          in   1   stage-1 instruction valid
//   take_branch_s1    in   1   branch/jump resolved taken in stage 1
//   branch_target_s1  in  32   branch/jump target
//   trap_request      in   1   trap/interrupt/mret redirect (beats branches)
//   trap_target       in  32   trap/return target
//   redirect_ready    in   1   fetch accepts the redirect this cycle
//   redirect_valid    out  1   redirect request pending
//   redirect_pc       out 32   pending redirect target
//   flush_s0          out  1   squash stage-0 instruction
//   stall_s1          out  1   hold stage 1
//   misaligned_s1     out  1   one-cycle pulse, taken target not word aligned
//   busy              out  1   controller not in RUN
//   taken_count       out 32   (RVX_REDIRECT_STATS_EN) aligned branches taken
//   trap_count        out 32   (RVX_REDIRECT_STATS_EN) traps captured
//
// Optional feature macro: RVX_REDIRECT_STATS_EN adds the two event counters.
// ============================================================================
module rvx_core_redirect_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid_s1,
  input  logic        take_branch_s1,
  input  logic [31:0] branch_target_s1,
  input  logic        trap_request,
  input  logic [31:0] trap_target,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_s0,
  output logic        stall_s1,
  output logic        misaligned_s1,
  output logic        busy
`ifdef RVX_REDIRECT_STATS_EN
  ,
  output logic [31:0] taken_count,
  output logic [31:0] trap_count
`endif
);

  // Counter load value on acceptance; the counter holds "drain cycles left
  // after this one", so a load of N-1 yields exactly N DRAIN cycles.
  localparam logic [CNT_W-1:0] c_DRAIN_LOAD =
      (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);
  localparam logic c_DRAIN_EN = (DRAIN_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic             r_mis;
  logic             w_mis_nxt;

  logic w_branch;
  logic w_branch_aligned;

  // Traps always win over a branch resolved in the same cycle.
  assign w_branch         = valid_s1 & take_branch_s1 & ~trap_request;
  assign w_branch_aligned = w_branch & (branch_target_s1[1:0] == 2'b00);

  assign redirect_pc   = r_pc;
  assign misaligned_s1 = r_mis;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_pc    <= 32'h0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = r_pc;
    w_mis_nxt      = 1'b0;
    redirect_valid = 1'b0;
    flush_s0       = 1'b0;
    stall_s1       = 1'b0;
    busy           = 1'b1;

    case (r_state)
      ST_RUN: begin
        busy = 1'b0;
        if (trap_request) begin
          w_state_nxt = ST_REQ;
          w_pc_nxt    = trap_target;
          flush_s0    = 1'b1;
        end else if (w_branch_aligned) begin
          w_state_nxt = ST_REQ;
          w_pc_nxt    = branch_target_s1;
          flush_s0    = 1'b1;
        end else if (w_branch) begin
          w_mis_nxt = 1'b1;
        end
      end

      ST_REQ: begin
        redirect_valid = 1'b1;
        flush_s0       = 1'b1;
        stall_s1       = 1'b1;
        // A trap here re-arms REQ with the new target. If fetch accepts in the
        // same cycle, it takes the old r_pc and the trap becomes a fresh REQ.
        if (trap_request) begin
          w_pc_nxt = trap_target;
        end else if (redirect_ready) begin
          if (c_DRAIN_EN) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = c_DRAIN_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end

      ST_DRAIN: begin
        flush_s0 = 1'b1;
        stall_s1 = 1'b1;
        if (trap_request) begin
          w_state_nxt = ST_REQ;
          w_pc_nxt    = trap_target;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef RVX_REDIRECT_STATS_EN
  logic [31:0] r_taken_count;
  logic [31:0] r_trap_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_taken_count <= 32'h0;
      r_trap_count  <= 32'h0;
    end else begin
      if ((r_state == ST_RUN) && w_branch_aligned) begin
        r_taken_count <= r_taken_count + 32'd1;
      end
      // Every state captures a trap, so every asserted request is counted.
      if (trap_request) begin
        r_trap_count <= r_trap_count + 32'd1;
      end
    end
  end

  assign taken_count = r_taken_count;
  assign trap_count  = r_trap_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvx_core_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvx_core_redirect_ctrl
// Purpose  : Self-checking bench for rvx_core_redirect_ctrl (default build,
//            DRAIN_CYCLES=2): directed vector table, a backpressure sequence
//            and randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvx_core_redirect_ctrl;

  localparam int c_DRAIN = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_s1;
  logic        take_branch_s1;
  logic [31:0] branch_target_s1;
  logic        trap_request;
  logic [31:0] trap_target;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_s0;
  logic        stall_s1;
  logic        misaligned_s1;
  logic        busy;
`ifdef RVX_REDIRECT_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] trap_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  rvx_core_redirect_ctrl #(.DRAIN_CYCLES(c_DRAIN), .CNT_W(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .valid_s1        (valid_s1),
    .take_branch_s1  (take_branch_s1),
    .branch_target_s1(branch_target_s1),
    .trap_request    (trap_request),
    .trap_target     (trap_target),
    .redirect_ready  (redirect_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_s0        (flush_s0),
    .stall_s1        (stall_s1),
    .misaligned_s1   (misaligned_s1),
    .busy            (busy)
`ifdef RVX_REDIRECT_STATS_EN
    ,
    .taken_count     (taken_count),
    .trap_count      (trap_count)
`endif
  );

  // --------------------------------------------------------------------------
  // Behavioural model: a pending flag, a count of drain cycles still owed and
  // the target. "Running" means nothing pending and nothing owed.
  // --------------------------------------------------------------------------
  bit          m_pending;
  int          m_drain_left;
  logic [31:0] m_pc;
  bit          m_mis;

  function automatic bit m_running();
    return !m_pending && (m_drain_left == 0);
  endfunction

  function automatic void model_clock();
    bit br;
    br = valid_s1 && take_branch_s1 && !trap_request;
    if (!reset_n) begin
      m_pending = 0; m_drain_left = 0; m_pc = 32'h0; m_mis = 0;
      return;
    end
    m_mis = 0;
    if (m_pending) begin
      if (trap_request) m_pc = trap_target;
      else if (redirect_ready) begin
        m_pending    = 0;
        m_drain_left = c_DRAIN;
      end
    end else if (m_drain_left > 0) begin
      if (trap_request) begin
        m_pending = 1; m_drain_left = 0; m_pc = trap_target;
      end else begin
        m_drain_left = m_drain_left - 1;
      end
    end else begin
      if (trap_request) begin
        m_pending = 1; m_pc = trap_target;
      end else if (br && branch_target_s1[1:0] == 2'b00) begin
        m_pending = 1; m_pc = branch_target_s1;
      end else if (br) begin
        m_mis = 1;
      end
    end
  endfunction

  task automatic drive(input logic rn, input logic v, input logic t,
                       input logic [31:0] bt, input logic tr,
                       input logic [31:0] tt, input logic rd);
    reset_n = rn; valid_s1 = v; take_branch_s1 = t; branch_target_s1 = bt;
    trap_request = tr; trap_target = tt; redirect_ready = rd;
  endtask

  task automatic check(input string name, input logic e_rv,
                       input logic [31:0] e_pc, input logic e_fl,
                       input logic e_st, input logic e_mis, input logic e_busy);
    n_tests++;
    if (redirect_valid !== e_rv || redirect_pc !== e_pc || flush_s0 !== e_fl ||
        stall_s1 !== e_st || misaligned_s1 !== e_mis || busy !== e_busy) begin
      n_fail++;
      $display("FAIL %s: got rv=%b pc=%h fl=%b st=%b mis=%b busy=%b, expected rv=%b pc=%h fl=%b st=%b mis=%b busy=%b",
               name, redirect_valid, redirect_pc, flush_s0, stall_s1,
               misaligned_s1, busy, e_rv, e_pc, e_fl, e_st, e_mis, e_busy);
    end
  endtask

  // Finish the current cycle: clock edge, model update, settle.
  task automatic finish_cycle();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic check_model(input string name);
    logic e_fl;
    bit   br_al;
    br_al = valid_s1 && take_branch_s1 && !trap_request &&
            (branch_target_s1[1:0] == 2'b00);
    e_fl  = !m_running() || trap_request || br_al;
    check(name, m_pending, m_pc, e_fl, !m_running(), m_mis, !m_running());
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors: inputs of one cycle and the outputs expected in it.
  // --------------------------------------------------------------------------
  typedef struct {
    logic        rn, v, t, tr, rd;
    logic [31:0] bt, tt;
    logic        rv, fl, st, mis, bsy;
    logic [31:0] pc;
  } vec_t;

  localparam int c_NV = 22;
  vec_t vecs[c_NV];

  function automatic vec_t mk(input logic rn, input logic v, input logic t,
                              input logic [31:0] bt, input logic tr,
                              input logic [31:0] tt, input logic rd,
                              input logic rv, input logic [31:0] pc,
                              input logic fl, input logic st, input logic mis,
                              input logic bsy);
    vec_t x;
    x.rn = rn; x.v = v; x.t = t; x.bt = bt; x.tr = tr; x.tt = tt; x.rd = rd;
    x.rv = rv; x.pc = pc; x.fl = fl; x.st = st; x.mis = mis; x.bsy = bsy;
    return x;
  endfunction

  initial begin
    //              rn v t bt            tr tt            rd  rv pc            fl st mis busy
    // aligned branch, accepted the following cycle, two drain cycles
    vecs[0]  = mk(1, 1, 1, 32'h0000_0100, 0, 32'h0,        0,  0, 32'h0,        1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h0000_0100, 1, 1, 0, 1);
    vecs[2]  = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0000_0100, 1, 1, 0, 1);
    vecs[3]  = mk(1, 1, 1, 32'h0000_0200, 0, 32'h0,        0,  0, 32'h0000_0100, 1, 1, 0, 1);
    vecs[4]  = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0000_0100, 0, 0, 0, 0);
    // misaligned branch: one pulse, no redirect
    vecs[5]  = mk(1, 1, 1, 32'h0000_0102, 0, 32'h0,        1,  0, 32'h0000_0100, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,         0, 32'h0,        1,  0, 32'h0000_0100, 0, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0000_0100, 0, 0, 0, 0);
    // trap and branch together: trap target wins
    vecs[8]  = mk(1, 1, 1, 32'h0000_0200, 1, 32'h8000_0000, 0, 0, 32'h0000_0100, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, 32'h8000_0000, 1, 1, 0, 1);
    // trap overrides pending target; branch in REQ ignored
    vecs[10] = mk(1, 0, 0, 32'h0,         1, 32'h0000_0400, 0, 1, 32'h8000_0000, 1, 1, 0, 1);
    vecs[11] = mk(1, 1, 1, 32'h0000_0300, 0, 32'h0,        0,  1, 32'h0000_0400, 1, 1, 0, 1);
    // trap with ready: handshake of 0x400, new REQ for 0x500 without drain
    vecs[12] = mk(1, 0, 0, 32'h0,         1, 32'h0000_0500, 1, 1, 32'h0000_0400, 1, 1, 0, 1);
    vecs[13] = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, 32'h0000_0500, 1, 1, 0, 1);
    vecs[14] = mk(1, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h0000_0500, 1, 1, 0, 1);
    // trap aborts drain
    vecs[15] = mk(1, 0, 0, 32'h0,         1, 32'h0000_0600, 0, 0, 32'h0000_0500, 1, 1, 0, 1);
    vecs[16] = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  1, 32'h0000_0600, 1, 1, 0, 1);
    vecs[17] = mk(1, 0, 0, 32'h0,         0, 32'h0,        1,  1, 32'h0000_0600, 1, 1, 0, 1);
    // reset while the drain counter is 1
    vecs[18] = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0000_0600, 1, 1, 0, 1);
    vecs[19] = mk(0, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0000_0600, 1, 1, 0, 1);
    vecs[20] = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0,         0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 32'h0,         0, 32'h0,        0,  0, 32'h0,         0, 0, 0, 0);

    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    finish_cycle();
    finish_cycle();
    @(negedge clock);
    check("reset_state", 0, 32'h0, 0, 0, 0, 0);
    finish_cycle();

    for (int i = 0; i < c_NV; i++) begin
      drive(vecs[i].rn, vecs[i].v, vecs[i].t, vecs[i].bt, vecs[i].tr,
            vecs[i].tt, vecs[i].rd);
      @(negedge clock);
      check($sformatf("vec%0d", i), vecs[i].rv, vecs[i].pc, vecs[i].fl,
            vecs[i].st, vecs[i].mis, vecs[i].bsy);
      finish_cycle();
    end

    // Backpressure: ready low for five REQ cycles, handshake on the sixth.
    drive(1, 1, 1, 32'h0000_0100, 0, 32'h0, 0);
    @(negedge clock);
    check("bp_event", 0, 32'h0, 1, 0, 0, 0);
    finish_cycle();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 0, 32'h0, 0, 32'h0, (i == 6));
      @(negedge clock);
      check($sformatf("bp_req%0d", i), 1, 32'h0000_0100, 1, 1, 0, 1);
      finish_cycle();
    end
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clock);
    check("bp_drain", 0, 32'h0000_0100, 1, 1, 0, 1);
    finish_cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bt;
      bt = $urandom;
      bt[1:0] = ($urandom_range(0, 3) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      drive(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom), bt,
            ($urandom_range(0, 7) == 0), $urandom, 1'($urandom));
      @(negedge clock);
      check_model($sformatf("rand%0d", i));
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
